mux8_rr_sched: RTL and testbench

Round-robin scheduler that shares the two-level 8:1 mux (`l2mux`) among eight requesters. It arbitrates requests, drives the mux select lines (`sabcd`, `sxy`, `sz`), and samples the mux output `y8`. The sampled data is presented to a single downstream consumer over a valid/ready handshake, with a bounded burst per grant. It sits directly in front of `l2mux`; `y4` is not used.

---
 rtl/mux8_rr_sched_pkg.sv | 22 ++
 rtl/mux8_rr_sched_if.sv | 26 ++
 rtl/l2mux.sv | 18 +
 rtl/mux8_rr_sched_rr_pick8.sv | 26 ++
 rtl/mux8_rr_sched.sv | 101 ++++++++++
 tb/tb_mux8_rr_sched.sv | 188 ++++++++++++++++++
 6 files changed

// File: rtl/mux8_rr_sched_pkg.sv
// Shared constants, FSM encoding and the registered datapath record for the
// eight-way round-robin scheduler in front of l2mux.
package mux_sched_pkg;

   localparam int N_REQ = 8;
   localparam int SEL_W = 3;

   typedef enum logic [1:0] {IDLE, SETTLE, XFER} state_t;

   typedef struct packed {
      logic [SEL_W-1:0] sel;
      logic [SEL_W-1:0] ptr;
      logic [N_REQ-1:0] gnt;
      logic             vld;
      logic             data;
   } sched_reg_t;

   function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] i);
      return N_REQ'(1) << i;
   endfunction

endpackage

// File: rtl/mux8_rr_sched_if.sv
// Bundle between the scheduler, the shared l2mux and the downstream consumer.
interface mux8_rr_sched_if;
   import mux_sched_pkg::*;

   logic [N_REQ-1:0] req;
   logic             mux_y;
   logic             out_ready;
   logic             sabcd;
   logic             sxy;
   logic             sz;
   logic [N_REQ-1:0] gnt;
   logic             out_valid;
   logic             out_data;
   logic             busy;

   modport slave (
      input  req, mux_y, out_ready,
      output sabcd, sxy, sz, gnt, out_valid, out_data, busy
   );

   modport master (
      output req, mux_y, out_ready,
      input  sabcd, sxy, sz, gnt, out_valid, out_data, busy
   );

endinterface

// File: rtl/l2mux.sv
// Two-level 8:1 mux: sabcd/sxy pick within a group of four, sz picks the group.
module l2mux (
   input  logic a1, b1, c1, d1,
   input  logic a2, b2, c2, d2,
   input  logic sabcd,
   input  logic sxy,
   input  logic sz,
   output logic y4,
   output logic y8
);

   logic y4b;

   assign y4  = sxy ? (sabcd ? d1 : c1) : (sabcd ? b1 : a1);
   assign y4b = sxy ? (sabcd ? d2 : c2) : (sabcd ? b2 : a2);
   assign y8  = sz ? y4b : y4;

endmodule

// File: rtl/mux8_rr_sched_rr_pick8.sv
// Round-robin pick: rotate req so ptr lands on bit 0, take the lowest set bit,
// then add ptr back to get the absolute winner index.
module rr_pick8
   import mux_sched_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [SEL_W-1:0] ptr,
   output logic             any,
   output logic [SEL_W-1:0] idx
);

   logic [N_REQ-1:0] rot;
   logic [SEL_W-1:0] off;

   assign rot = N_REQ'({req, req} >> ptr);

   always_comb begin
      off = '0;
      for (int i = N_REQ - 1; i >= 0; i--)
         if (rot[i]) off = SEL_W'(i);
   end

   assign any = |req;
   assign idx = ptr + off;

endmodule

// File: rtl/mux8_rr_sched.sv
// Round-robin owner of the shared l2mux: selects one requester, samples y8,
// and streams up to BURST beats per grant over valid/ready.
module mux8_rr_sched
   import mux_sched_pkg::*;
#(
   parameter int BURST = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   mux8_rr_sched_if.slave    bus
);

   localparam int CW = $clog2(BURST) + 1;

   state_t           state, state_nxt;
   sched_reg_t       r, r_nxt;
   logic [CW-1:0]    beat_cnt, beat_nxt, beat_inc;
   logic             any;
   logic [SEL_W-1:0] idx;
   logic             hs, rel;

   rr_pick8 u_pick (
      .req (bus.req),
      .ptr (r.ptr),
      .any (any),
      .idx (idx)
   );

   assign hs       = r.vld && bus.out_ready;
   assign beat_inc = beat_cnt + CW'(1);
   // Release is decided on the handshake itself, so a dropped request still
   // lets the already-presented beat complete.
   assign rel      = (state == XFER) && hs &&
                     ((beat_inc == CW'(BURST)) || !bus.req[r.sel]);

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (any) state_nxt = SETTLE;
         SETTLE:  state_nxt = XFER;
         XFER:    if (rel) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // sel is only ever loaded on IDLE->SETTLE, so the mux path is fixed for the burst.
   always_comb begin
      r_nxt    = r;
      beat_nxt = beat_cnt;
      case (state)
         IDLE: begin
            if (any) begin
               r_nxt.sel = idx;
               r_nxt.gnt = onehot(idx);
               beat_nxt  = '0;
            end else begin
               r_nxt.gnt = '0;
            end
         end
         SETTLE: begin
            r_nxt.data = bus.mux_y;
            r_nxt.vld  = 1'b1;
         end
         XFER: begin
            if (hs) begin
               beat_nxt = beat_inc;
               if (rel) begin
                  r_nxt.vld = 1'b0;
                  r_nxt.gnt = '0;
                  r_nxt.ptr = r.sel + 1'b1;
               end else begin
                  r_nxt.data = bus.mux_y;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r        <= '0;
         beat_cnt <= '0;
      end else begin
         r        <= r_nxt;
         beat_cnt <= beat_nxt;
      end
   end

   assign {bus.sz, bus.sxy, bus.sabcd} = r.sel;
   assign bus.gnt       = r.gnt;
   assign bus.out_valid = r.vld;
   assign bus.out_data  = r.data;
   assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_mux8_rr_sched.sv
// Directed plus randomized bench for mux8_rr_sched driving a real l2mux.
module tb_mux8_rr_sched;
   import mux_sched_pkg::*;

   localparam int BURST = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] mdat;
   logic       y4;
   int         checks = 0;
   int         errors = 0;
   int         mptr = 0;
   int         w;

   always #5 clk = ~clk;

   mux8_rr_sched_if bus ();

   l2mux u_mux (
      .a1(mdat[0]), .b1(mdat[1]), .c1(mdat[2]), .d1(mdat[3]),
      .a2(mdat[4]), .b2(mdat[5]), .c2(mdat[6]), .d2(mdat[7]),
      .sabcd(bus.sabcd), .sxy(bus.sxy), .sz(bus.sz),
      .y4(y4), .y8(bus.mux_y)
   );

   mux8_rr_sched #(.BURST(BURST)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int pick(input logic [7:0] r, input int p);
      for (int k = 0; k < 8; k++)
         if (r[(p + k) % 8]) return (p + k) % 8;
      return 0;
   endfunction

   // One full grant: exp_w >= 0 forces the winner named by the test plan,
   // otherwise the round-robin model chooses it.
   task automatic burst(input logic [7:0] r, input int pct, input int stall,
                        input int drop_at, input int exp_w, output int win);
      int         nb, cyc;
      logic       rdy, rel, eo, nxt_eo, done;
      logic [7:0] cur;
      win = (exp_w >= 0) ? exp_w : pick(r, mptr);
      bus.req = r;
      bus.out_ready = 1'b0;
      step();
      chk("grant_gnt", bus.gnt, onehot(3'(win)));
      chk("grant_sel", {bus.sz, bus.sxy, bus.sabcd}, win);
      chk("grant_busy", bus.busy, 1);
      chk("grant_novalid", bus.out_valid, 0);
      bus.req = 8'($urandom);
      step();
      chk("settle_valid", bus.out_valid, 1);
      chk("settle_data", bus.out_data, mdat[win]);
      chk("settle_sel", {bus.sz, bus.sxy, bus.sabcd}, win);
      eo = mdat[win];
      bus.req = r;
      nb = 0;
      done = 1'b0;
      for (cyc = 0; cyc < 300 && !done; cyc++) begin
         rdy = (stall > 0) ? 1'b0 : ($urandom_range(99) < pct);
         if (stall > 0) stall--;
         bus.out_ready = rdy;
         mdat = 8'($urandom);
         cur = bus.req;
         rel = rdy && ((nb + 1 == BURST) || !cur[win]);
         nxt_eo = (rdy && !rel) ? mdat[win] : eo;
         step();
         if (rdy) nb++;
         if (rel) begin
            chk("rel_valid", bus.out_valid, 0);
            chk("rel_gnt", bus.gnt, 0);
            chk("rel_busy", bus.busy, 0);
            chk("rel_sel", {bus.sz, bus.sxy, bus.sabcd}, win);
            mptr = (win + 1) % 8;
            done = 1'b1;
         end else begin
            chk("xfer_valid", bus.out_valid, 1);
            chk("xfer_data", bus.out_data, nxt_eo);
            chk("xfer_gnt", bus.gnt, onehot(3'(win)));
            chk("xfer_sel", {bus.sz, bus.sxy, bus.sabcd}, win);
            eo = nxt_eo;
            if (rdy && nb == drop_at) bus.req = r & ~onehot(3'(win));
         end
      end
      chk("burst_done", done, 1);
      bus.out_ready = 1'b0;
   endtask

   initial begin
      bus.req = '0;
      bus.out_ready = 1'b0;
      mdat = 8'($urandom);

      // reset and idle
      step();
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("idle_gnt", bus.gnt, 0);
         chk("idle_valid", bus.out_valid, 0);
         chk("idle_sel", {bus.sz, bus.sxy, bus.sabcd}, 0);
         chk("idle_busy", bus.busy, 0);
      end
      chk("idle_y4", y4, mdat[0]);
      chk("idle_data", bus.out_data, 0);

      // single requester, two consecutive grants across the dead cycle
      burst(8'h20, 100, 0, 0, 5, w);
      burst(8'h20, 100, 0, 0, 5, w);

      // round-robin wrap from ptr=0
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      mptr = 0;
      burst(8'h81, 100, 0, 0, 0, w);
      burst(8'h81, 100, 0, 0, 7, w);
      burst(8'h81, 100, 0, 0, 0, w);
      burst(8'h81, 100, 0, 0, 7, w);
      burst(8'h40, 100, 0, 0, 6, w);
      burst(8'h81, 100, 0, 0, 7, w);
      burst(8'h81, 100, 0, 0, 0, w);

      // backpressure: 5 stalled cycles, then a partially-ready stream
      burst(8'h04, 60, 5, 0, 2, w);

      // early drop after beat 1, next pick must start at 4
      burst(8'h08, 100, 0, 1, 3, w);
      burst(8'hff, 100, 0, 0, 4, w);

      // reset during beat 2 of a grant to 6
      bus.req = 8'h40;
      bus.out_ready = 1'b1;
      step();
      chk("mid_gnt", bus.gnt, 8'h40);
      step();
      chk("mid_settle", bus.out_valid, 1);
      step();
      chk("mid_beat2_valid", bus.out_valid, 1);
      rst_n = 1'b0;
      step();
      chk("mid_rst_gnt", bus.gnt, 0);
      chk("mid_rst_valid", bus.out_valid, 0);
      chk("mid_rst_data", bus.out_data, 0);
      chk("mid_rst_sel", {bus.sz, bus.sxy, bus.sabcd}, 0);
      chk("mid_rst_busy", bus.busy, 0);
      rst_n = 1'b1;
      mptr = 0;
      burst(8'h41, 100, 0, 0, 0, w);

      // randomized traffic against the round-robin model
      for (int n = 0; n < 25; n++) begin
         logic [7:0] rr;
         rr = 8'($urandom);
         if (rr == 8'h00) rr = 8'h01;
         burst(rr, $urandom_range(30, 100), $urandom_range(0, 3),
               $urandom_range(0, BURST), -1, w);
         bus.req = '0;
         for (int g = $urandom_range(0, 2); g > 0; g--) begin
            step();
            chk("gap_gnt", bus.gnt, 0);
            chk("gap_busy", bus.busy, 0);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
